mem_port_arbiter: RTL and testbench

Sequencer and arbiter that shares the CPU's single RAM/bus port between the IF-stage instruction fetch and the MEM-stage load/store access. It grants one requester at a time and drives a registered bus transaction held until the slave acknowledges or a timeout expires. It returns read data with a one-cycle done pulse and raises a pipeline stall request while any access is outstanding.

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM/bus port between IF instruction fetch and MEM load/store.
// One registered bus transaction at a time, completed by bus_ack or a timeout abort.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_done,
    output logic              inst_err,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_sel,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic              data_err,
    output logic              stall_req,
    output logic              bus_en,
    output logic              bus_we,
    output logic [3:0]        bus_sel,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ack
);

    typedef enum logic [1:0] {IDLE, DATA_ACC, INST_ACC} state_t;

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_data_q, last_data_d;  // 1: last grant went to MEM
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_en_q, bus_en_d;
    logic              bus_we_q, bus_we_d;
    logic [3:0]        bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              inst_done_q, inst_done_d;
    logic              inst_err_q, inst_err_d;
    logic              data_done_q, data_done_d;
    logic              data_err_q, data_err_d;
    logic              grant_data, grant_inst;
    logic              unused_addr_bits;

    // Byte alignment is handled by sel, so the address low bits are dropped.
    assign unused_addr_bits = ^{inst_addr[1:0], data_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_data_q  <= 1'b0;
            cnt_q        <= '0;
            bus_en_q     <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_sel_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            inst_err_q   <= 1'b0;
            data_done_q  <= 1'b0;
            data_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_data_q  <= last_data_d;
            cnt_q        <= cnt_d;
            bus_en_q     <= bus_en_d;
            bus_we_q     <= bus_we_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_done_q  <= inst_done_d;
            inst_err_q   <= inst_err_d;
            data_done_q  <= data_done_d;
            data_err_q   <= data_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_data_d  = last_data_q;
        cnt_d        = cnt_q;
        bus_en_d     = bus_en_q;
        bus_we_d     = bus_we_q;
        bus_sel_d    = bus_sel_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_done_d  = 1'b0;
        inst_err_d   = 1'b0;
        data_done_d  = 1'b0;
        data_err_d   = 1'b0;
        // On a tie, MEM wins unless it was the last one served.
        grant_data   = data_req & (~inst_req | ~last_data_q);
        grant_inst   = inst_req & ~grant_data;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d     = DATA_ACC;
                    last_data_d = 1'b1;
                    cnt_d       = '0;
                    bus_en_d    = 1'b1;
                    bus_we_d    = data_we;
                    bus_sel_d   = data_sel;
                    bus_addr_d  = {data_addr[ADDR_W-1:2], 2'b00};
                    bus_wdata_d = data_wdata;
                end else if (grant_inst) begin
                    state_d     = INST_ACC;
                    last_data_d = 1'b0;
                    cnt_d       = '0;
                    bus_en_d    = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_sel_d   = 4'b1111;
                    bus_addr_d  = {inst_addr[ADDR_W-1:2], 2'b00};
                    bus_wdata_d = '0;
                end
            end
            DATA_ACC, INST_ACC: begin
                if (bus_ack || cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    bus_en_d  = 1'b0;
                    bus_we_d  = 1'b0;
                    bus_sel_d = '0;
                    // Ack wins over a timeout landing on the same edge.
                    if (state_q == DATA_ACC) begin
                        data_done_d = 1'b1;
                        data_err_d  = ~bus_ack;
                        if (!bus_ack)
                            data_rdata_d = '0;
                        else if (!bus_we_q)
                            data_rdata_d = bus_rdata;
                    end else begin
                        inst_done_d  = 1'b1;
                        inst_err_d   = ~bus_ack;
                        inst_rdata_d = bus_ack ? bus_rdata : '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign inst_rdata = inst_rdata_q;
    assign inst_done  = inst_done_q;
    assign inst_err   = inst_err_q;
    assign data_rdata = data_rdata_q;
    assign data_done  = data_done_q;
    assign data_err   = data_err_q;
    assign bus_en     = bus_en_q;
    assign bus_we     = bus_we_q;
    assign bus_sel    = bus_sel_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign stall_req  = (inst_req & ~inst_done_q) | (data_req & ~data_done_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: loads, stores, arbitration ties,
// timeout abort, mid-access reset and request drop.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_done, inst_err;
    logic              data_req, data_we;
    logic [3:0]        data_sel;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata, data_rdata;
    logic              data_done, data_err;
    logic              stall_req;
    logic              bus_en, bus_we;
    logic [3:0]        bus_sel;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata, bus_rdata;
    logic              bus_ack;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_done(inst_done), .inst_err(inst_err),
        .data_req(data_req), .data_we(data_we), .data_sel(data_sel),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_done(data_done), .data_err(data_err), .stall_req(stall_req),
        .bus_en(bus_en), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int hi_cnt;
        int early_done;

        rst = 1'b1; inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_sel = '0; data_addr = '0; data_wdata = '0;
        bus_rdata = '0; bus_ack = 1'b0;
        cyc(); cyc();
        chk("rst_bus_en", bus_en, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_sel", bus_sel, 0);
        chk("rst_rdata", {inst_rdata, data_rdata}, 0);
        chk("rst_done_err", {inst_done, inst_err, data_done, data_err}, 0);
        chk("rst_stall", stall_req, 0);
        rst = 1'b0;

        // Single load
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h104; data_sel = 4'hF;
        #1 chk("ld_stall_req", stall_req, 1);
        cyc();
        chk("ld_bus_en", bus_en, 1);
        chk("ld_bus_addr", bus_addr, 32'h104);
        chk("ld_bus_we", bus_we, 0);
        chk("ld_bus_sel", bus_sel, 4'hF);
        chk("ld_no_done", data_done, 0);
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        cyc();
        chk("ld_done", {data_done, data_err, inst_done}, 3'b100);
        chk("ld_rdata", data_rdata, 32'hDEADBEEF);
        chk("ld_bus_released", {bus_en, bus_we, bus_sel}, 0);
        chk("ld_stall_fall", stall_req, 0);
        data_req = 1'b0; bus_ack = 1'b0;
        cyc();
        chk("ld_done_pulse", data_done, 0);

        // Store with a single lane
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h203; data_sel = 4'b1000;
        data_wdata = 32'h11223344;
        cyc();
        chk("st_bus_addr", bus_addr, 32'h200);
        chk("st_bus_sel", bus_sel, 4'b1000);
        chk("st_bus_wdata", bus_wdata, 32'h11223344);
        chk("st_bus_we", bus_we, 1);
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        cyc();
        chk("st_done", {data_done, data_err}, 2'b10);
        chk("st_rdata_kept", data_rdata, 32'hDEADBEEF);
        data_req = 1'b0; data_we = 1'b0; bus_ack = 1'b0;
        cyc();

        // Simultaneous requests after reset: data, then inst, then data
        rst = 1'b1; cyc(); rst = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h40;
        data_req = 1'b1; data_addr = 32'h80; data_sel = 4'b0011;
        cyc();
        chk("tie1_data_addr", bus_addr, 32'h80);
        chk("tie1_data_sel", bus_sel, 4'b0011);
        bus_ack = 1'b1; bus_rdata = 32'hAAAA0001;
        cyc();
        chk("tie1_done", {data_done, inst_done}, 2'b10);
        chk("tie1_rdata", data_rdata, 32'hAAAA0001);
        chk("tie1_stall_inst", stall_req, 1);
        data_req = 1'b0; bus_rdata = 32'hBBBB0002;
        cyc();
        chk("tie2_inst_addr", bus_addr, 32'h40);
        chk("tie2_inst_bus", {bus_en, bus_we, bus_sel}, 6'b101111);
        cyc();
        chk("tie2_done", {inst_done, inst_err, data_done}, 3'b100);
        chk("tie2_inst_rdata", inst_rdata, 32'hBBBB0002);
        chk("tie2_data_rdata_kept", data_rdata, 32'hAAAA0001);
        data_req = 1'b1; data_addr = 32'h90; bus_ack = 1'b0;
        cyc();
        chk("tie3_data_addr", bus_addr, 32'h90);
        bus_ack = 1'b1; bus_rdata = 32'h12345678;
        cyc();
        chk("tie3_done", {data_done, inst_done}, 2'b10);
        inst_req = 1'b0; data_req = 1'b0; bus_ack = 1'b0;
        cyc();

        // Slave never acks
        data_req = 1'b1; data_addr = 32'h300;
        cyc();
        chk("to_bus_en", bus_en, 1);
        hi_cnt = 1; early_done = 0;
        for (int i = 1; i < TIMEOUT; i++) begin
            cyc();
            if (bus_en) hi_cnt++;
            if (data_done) early_done++;
        end
        chk("to_bus_en_cycles", hi_cnt, TIMEOUT);
        chk("to_no_early_done", early_done, 0);
        cyc();
        chk("to_done_err", {data_done, data_err}, 2'b11);
        chk("to_rdata_zero", data_rdata, 0);
        chk("to_bus_en_drop", bus_en, 0);
        data_req = 1'b0;
        cyc();
        chk("to_err_pulse", data_err, 0);
        data_req = 1'b1; data_addr = 32'h304;
        cyc();
        chk("to_next_addr", bus_addr, 32'h304);
        bus_ack = 1'b1; bus_rdata = 32'h55;
        cyc();
        chk("to_next_done", {data_done, data_err}, 2'b10);
        chk("to_next_rdata", data_rdata, 32'h55);
        data_req = 1'b0; bus_ack = 1'b0;
        cyc();

        // Reset during the third wait cycle
        inst_req = 1'b1; inst_addr = 32'h500;
        cyc();
        chk("rm_bus_en", bus_en, 1);
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        chk("rm_bus_en_drop", bus_en, 0);
        chk("rm_no_done", {inst_done, inst_err}, 0);
        rst = 1'b0; inst_addr = 32'h600; bus_ack = 1'b1; bus_rdata = 32'h66;
        cyc();
        chk("rm_fresh_addr", bus_addr, 32'h600);
        chk("rm_fresh_not_yet", inst_done, 0);
        cyc();
        chk("rm_fresh_done", {inst_done, inst_err}, 2'b10);
        chk("rm_fresh_rdata", inst_rdata, 32'h66);
        inst_req = 1'b0; bus_ack = 1'b0;
        cyc();

        // Request dropped while waiting
        inst_req = 1'b1; inst_addr = 32'h700;
        cyc();
        inst_req = 1'b0; inst_addr = 32'hFFF0;
        cyc();
        chk("drop_bus_held", {bus_en, bus_addr}, {1'b1, 32'h700});
        chk("drop_no_done", inst_done, 0);
        bus_ack = 1'b1; bus_rdata = 32'h77;
        cyc();
        chk("drop_done", inst_done, 1);
        chk("drop_rdata", inst_rdata, 32'h77);
        bus_ack = 1'b0;
        cyc();
        chk("drop_idle", {inst_done, bus_en}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
